// File: rtl/pulse_stretcher.sv
// Rebuilds single-cycle strobes into level pulses of programmable width,
// each followed by a programmable forced-low gap; rejected strobes are counted.
module pulse_stretcher #(
  parameter int unsigned WIDTH_W = 8,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned DROP_W  = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pulse_in,
  input  logic [WIDTH_W-1:0] width,
  input  logic [GAP_W-1:0]   gap,
  input  logic               retrig,
  output logic               dout,
  output logic               busy,
  output logic               accept,
  output logic [DROP_W-1:0]  drop_cnt
);

  // One shared down-counter times both the high phase and the gap phase.
  localparam int unsigned CNT_W = (WIDTH_W > GAP_W) ? WIDTH_W : GAP_W;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [WIDTH_W-1:0]  wlat, wlat_nxt;
  logic [GAP_W-1:0]    glat, glat_nxt;
  logic [DROP_W-1:0]   drop_nxt;
  logic                drop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    wlat_nxt  = wlat;
    glat_nxt  = glat;
    accept    = 1'b0;
    drop      = 1'b0;

    unique case (state)
      IDLE: begin
        if (pulse_in) begin
          if (width != '0) begin
            accept    = 1'b1;
            state_nxt = HIGH;
            cnt_nxt   = CNT_W'(width);
            wlat_nxt  = width;
            glat_nxt  = gap;
          end else begin
            drop = 1'b1;
          end
        end
      end

      HIGH: begin
        if (pulse_in && retrig) begin
          // Retrigger reloads the width latched at acceptance, not the live input.
          accept  = 1'b1;
          cnt_nxt = CNT_W'(wlat);
        end else begin
          drop = pulse_in;
          if (cnt == CNT_ONE) begin
            if (glat == '0) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = GAP;
              cnt_nxt   = CNT_W'(glat);
            end
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end

      GAP: begin
        drop = pulse_in;
        if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Saturate at all-ones rather than wrapping back to zero.
    drop_nxt = drop_cnt;
    if (drop && (drop_cnt != '1)) begin
      drop_nxt = drop_cnt + DROP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      wlat     <= '0;
      glat     <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wlat     <= wlat_nxt;
      glat     <= glat_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  assign dout = (state == HIGH);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: directed cases with literal expectations plus random
// strobes compared every cycle against a timeline model of the stretcher.
module tb_pulse_stretcher;

  logic        clk = 1'b0;
  logic        resetn, pulse_in, retrig;
  logic [7:0]  width, gap;
  logic        dout, busy, accept;
  logic [15:0] drop_cnt;
  logic        s_dout, s_busy, s_accept;
  logic [1:0]  s_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_stretcher u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .pulse_in (pulse_in),
    .width    (width),
    .gap      (gap),
    .retrig   (retrig),
    .dout     (dout),
    .busy     (busy),
    .accept   (accept),
    .drop_cnt (drop_cnt)
  );

  // Narrow drop counter so saturation is reachable in a short run.
  pulse_stretcher #(.DROP_W(2)) u_sat (
    .clk      (clk),
    .resetn   (resetn),
    .pulse_in (pulse_in),
    .width    (width),
    .gap      (gap),
    .retrig   (retrig),
    .dout     (s_dout),
    .busy     (s_busy),
    .accept   (s_accept),
    .drop_cnt (s_drop_cnt)
  );

  // Model: absolute cycle numbers of the last high cycle and last gap cycle.
  typedef enum {M_IDLE, M_HIGH, M_GAP} mstate_t;
  longint      t        = 0;
  longint      high_end = -1;
  longint      gap_end  = -1;
  int unsigned wl = 0, gl = 0, drops = 0;
  bit          checking = 0;

  function automatic mstate_t mstate();
    if (t <= high_end) return M_HIGH;
    if (t <= gap_end)  return M_GAP;
    return M_IDLE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic model_edge();
    mstate_t st;
    st = mstate();
    if (!resetn) begin
      high_end = t;
      gap_end  = t;
      wl       = 0;
      gl       = 0;
      drops    = 0;
    end else if (pulse_in) begin
      if (st == M_IDLE && width != 0) begin
        wl       = width;
        gl       = gap;
        high_end = t + wl;
        gap_end  = high_end + gl;
      end else if (st == M_HIGH && retrig) begin
        high_end = t + wl;
        gap_end  = high_end + gl;
      end else begin
        drops++;
      end
    end
    t++;
  endtask

  task automatic drive(input logic p, input logic [7:0] w, input logic [7:0] g,
                       input logic r, input logic rn);
    pulse_in = p;
    width    = w;
    gap      = g;
    retrig   = r;
    resetn   = rn;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (!resetn) checking = 1;
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 8'd0, 8'd0, 0, 0);
    clk_edge();
    drive(0, 8'd0, 8'd0, 0, 1);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      mstate_t     st;
      logic        exp_acc;
      int unsigned exp16, exp2;
      st      = mstate();
      exp_acc = pulse_in && ((st == M_IDLE && width != 0) || (st == M_HIGH && retrig));
      exp16   = (drops > 65535) ? 65535 : drops;
      exp2    = (drops > 3) ? 3 : drops;
      check("dout", dout, st == M_HIGH);
      check("busy", busy, st != M_IDLE);
      check("drop_cnt", drop_cnt, exp16);
      check("sat_dout", s_dout, st == M_HIGH);
      check("sat_drop_cnt", s_drop_cnt, exp2);
      if (resetn) begin
        check("accept", accept, exp_acc);
        check("sat_accept", s_accept, exp_acc);
      end
    end
  end

  initial begin
    drive(0, 8'd0, 8'd0, 0, 0);
    clk_edge();
    clk_edge();
    drive(0, 8'd0, 8'd0, 0, 1);
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", drop_cnt, 0);
    check("reset_accept", accept, 0);

    // width=3 gap=2, one strobe at c0
    drive(1, 8'd3, 8'd2, 0, 1); #1;
    check("t1_accept_c0", accept, 1);
    clk_edge();
    for (int c = 1; c <= 6; c++) begin
      drive(0, 8'd3, 8'd2, 0, 1); #1;
      check("t1_dout", dout, (c <= 3));
      check("t1_busy", busy, (c <= 5));
      check("t1_accept", accept, 0);
      clk_edge();
    end

    // width=4, strobes at c0 and c2, with and without retrigger
    for (int r = 1; r >= 0; r--) begin
      apply_reset();
      for (int c = 0; c <= 8; c++) begin
        drive((c == 0 || c == 2), 8'd4, 8'd0, r[0], 1); #1;
        check(r ? "t2_dout" : "t3_dout", dout, r ? (c >= 1 && c <= 6) : (c >= 1 && c <= 4));
        clk_edge();
      end
      check(r ? "t2_drop" : "t3_drop", drop_cnt, r ? 0 : 1);
    end

    // width=2 gap=3, strobes c0 (accept), c4 (in gap, dropped), c6 (accept)
    apply_reset();
    for (int c = 0; c <= 9; c++) begin
      drive((c == 0 || c == 4 || c == 6), 8'd2, 8'd3, 0, 1); #1;
      check("t4_dout", dout, ((c >= 1 && c <= 2) || (c >= 7 && c <= 8)));
      if (c == 4) check("t4_accept_c4", accept, 0);
      if (c == 6) check("t4_accept_c6", accept, 1);
      clk_edge();
    end
    check("t4_drop", drop_cnt, 1);

    // width=0 strobes are dropped; narrow counter saturates
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1, 8'd0, 8'd0, 0, 1); #1;
      check("t5_accept", accept, 0);
      check("t5_dout", dout, 0);
      clk_edge();
    end
    drive(0, 8'd0, 8'd0, 0, 1); #1;
    check("t5_drop", drop_cnt, 5);
    check("t5_sat_drop", s_drop_cnt, 3);

    // reset mid-HIGH clears everything; next strobe starts cleanly
    apply_reset();
    drive(1, 8'd8, 8'd0, 0, 1); clk_edge();
    drive(1, 8'd8, 8'd0, 0, 1); clk_edge();
    drive(0, 8'd8, 8'd0, 0, 1); #1;
    check("t6_dout_c2", dout, 1);
    check("t6_drop_c2", drop_cnt, 1);
    clk_edge();
    drive(0, 8'd8, 8'd0, 0, 0); clk_edge();
    drive(0, 8'd8, 8'd0, 0, 1); #1;
    check("t6_dout_c4", dout, 0);
    check("t6_busy_c4", busy, 0);
    check("t6_drop_c4", drop_cnt, 0);
    clk_edge();
    drive(1, 8'd8, 8'd0, 0, 1); #1;
    check("t6_accept_c5", accept, 1);
    clk_edge();
    drive(0, 8'd8, 8'd0, 0, 1); #1;
    check("t6_dout_c6", dout, 1);
    clk_edge();

    // Random strobes, widths, gaps, retrigger and occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic       p, r, rn;
      logic [7:0] w, g;
      rn = ($urandom_range(0, 299) != 0);
      p  = ($urandom_range(0, 9) < 4);
      w  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      g  = 8'($urandom_range(0, 4));
      r  = 1'($urandom_range(0, 1));
      drive(p, w, g, r, rn);
      clk_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
